dtw_ref_reader: RTL and testbench

DTW_REF_READER -- requirements
Module: dtw_ref_reader

---
 rtl/dtw_pkg.sv | 18 +
 rtl/dtw_ref_skid_fifo.sv | 64 ++++++
 rtl/dtw_ref_reader.sv | 147 ++++++++++++++
 tb/tb_dtw_ref_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW reference reader and the reference memory.
package dtw_pkg;

  localparam int DTW_WIDTH   = 16;
  localparam int DTW_PTR_WID = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dtw_state_e;

  // Counter width able to hold 0..depth inclusive.
  function automatic int dtw_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dtw_ref_skid_fifo.sv
// Small circular output buffer for the reference reader; flush empties it in one cycle.
module dtw_ref_skid_fifo
  import dtw_pkg::*;
#(
  parameter int WIDTH = DTW_WIDTH + 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = dtw_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Output reads as zero whenever nothing is held.
  assign dout    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/dtw_ref_reader.sv
// Streams a block of reference samples from one BRAM read port as a valid/ready beat stream.
// Optional DTW_REF_READER_RANGE_CHECK_EN rejects requests running past the top of memory.
module dtw_ref_reader
  import dtw_pkg::*;
#(
  parameter int WIDTH      = DTW_WIDTH,
  parameter int PTR_WID    = DTW_PTR_WID,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [PTR_WID-1:0] base_addr,
  input  logic [PTR_WID:0]   length,
  input  logic               abort,
  output logic [PTR_WID-1:0] mem_addr,
  input  logic [WIDTH-1:0]   mem_dout,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = dtw_cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  dtw_state_e       state;
  logic [PTR_WID:0] len_q;
  logic [PTR_WID:0] issued_q;
  logic             rd_vld_p1;
  logic             rd_last_p1;
  logic             done_q;
  logic             rd_en;
  logic             issued_last;
  logic             pop;
  logic             last_hs;
  logic             flush;
  logic             range_bad;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occ;
  logic             fifo_empty;
  logic             fifo_full;
  logic [WIDTH:0]   fifo_dout;

`ifdef DTW_REF_READER_RANGE_CHECK_EN
  localparam logic [PTR_WID+1:0] SPAN = {2'b01, {PTR_WID{1'b0}}};
  logic [PTR_WID+1:0] end_addr;
  assign end_addr  = {2'b00, base_addr} + {1'b0, length};
  assign range_bad = (end_addr > SPAN);
`else
  assign range_bad = 1'b0;
`endif

  assign pop         = m_valid & m_ready;
  assign occ         = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld_p1};
  assign issued_last = ((issued_q + 1'b1) == len_q);
  // A beat leaving this cycle frees the slot the new read will need two cycles later.
  assign rd_en       = (state == ST_RUN) & ~abort & (((occ < DEPTH_C) & ~fifo_full) | pop);
  assign last_hs     = (state == ST_DRAIN) & ~abort & pop & m_last;
  assign flush       = abort & (state != ST_IDLE);

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_dout[WIDTH-1:0];
  assign m_last  = fifo_dout[WIDTH];
  assign done    = done_q | last_hs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done_q    <= 1'b0;
      err       <= 1'b0;
      rd_vld_p1 <= 1'b0;
      issued_q  <= '0;
      mem_addr  <= '0;
    end else begin
      done_q    <= 1'b0;
      err       <= 1'b0;
      rd_vld_p1 <= rd_en;
      if (rd_en) begin
        mem_addr <= mem_addr + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (range_bad) begin
              err <= 1'b1;
            end else if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state    <= ST_RUN;
              busy     <= 1'b1;
              mem_addr <= base_addr;
              issued_q <= '0;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (rd_en && issued_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort || last_hs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // p0 -> p1: read issued this cycle, BRAM data and last tag valid next cycle
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) len_q <= length;
    rd_last_p1 <= issued_last;
  end

  // p1 -> buffer: returned word pushed with its last tag
  dtw_ref_skid_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (rd_vld_p1),
    .din   ({rd_last_p1, mem_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_dtw_ref_reader.sv
// Self-checking bench for dtw_ref_reader: directed vector table, abort/reset sequences, random transfers.
module tb_dtw_ref_reader;

  localparam int WIDTH      = 16;
  localparam int PTR_WID    = 18;
  localparam int FIFO_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [PTR_WID-1:0] base_addr;
  logic [PTR_WID:0]   length;
  logic               abort;
  logic [PTR_WID-1:0] mem_addr;
  logic [WIDTH-1:0]   mem_dout;
  logic [WIDTH-1:0]   m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic               busy;
  logic               done;
  logic               err;

  dtw_ref_reader #(
    .WIDTH      (WIDTH),
    .PTR_WID    (PTR_WID),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory contents: low address bits, upper bits folded in so wrap is visible.
  function automatic logic [WIDTH-1:0] mem_fn(input logic [PTR_WID-1:0] a);
    return a[15:0] ^ {a[17:16], 14'h0};
  endfunction

  always @(posedge clk) mem_dout <= mem_fn(mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor state
  logic [WIDTH-1:0]   got_d[$];
  logic               got_l[$];
  int                 got_c[$];
  int                 done_n, err_n, done_cyc, err_cyc;
  bit                 busy_seen, valid_seen, occ_on;
  logic [PTR_WID-1:0] base_q;
  logic [PTR_WID-1:0] iss_m;
  bit                 prev_stall = 1'b0;
  logic [WIDTH-1:0]   prev_d;
  logic               prev_l;

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_beat", 64'({prev_l, prev_d}), 64'({m_last, m_data}));
    end
    if (occ_on && busy) begin
      iss_m = mem_addr - base_q;
      chk("reads_outstanding_le_depth", 64'((int'(iss_m) - got_d.size()) <= FIFO_DEPTH), 64'd1);
    end
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      got_c.push_back(cyc);
    end
    if (m_valid) valid_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (done) begin done_n++; done_cyc = cyc; end
    if (err) begin err_n++; err_cyc = cyc; end
    prev_stall = m_valid && !m_ready && !abort && rstn;
    prev_d = m_data;
    prev_l = m_last;
  end

  // Ready generation: 0 always, 1 pattern 1,0,0,1, 2 random, 3 accept until rdy_lim beats
  int rdy_mode = 0;
  int pat_i = 0;
  int rdy_lim = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic set_ready();
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = pat[pat_i % 4];
      2:       m_ready = 1'($urandom % 2);
      3:       m_ready = (got_d.size() < rdy_lim);
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pat_i++;
    set_ready();
  endtask

  task automatic clr_mon();
    got_d.delete(); got_l.delete(); got_c.delete();
    done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [PTR_WID-1:0] b, input logic [PTR_WID:0] l,
                          input int rm, input bit lat, input bit spur);
    bit bad;
    int c0, budget, n;
    logic [PTR_WID-1:0] a;
    clr_mon();
    base_q = b; occ_on = 1'b1; rdy_mode = rm; pat_i = 0; set_ready();
    bad = 1'b0;
`ifdef DTW_REF_READER_RANGE_CHECK_EN
    bad = (longint'(b) + longint'(l)) > (longint'(1) << PTR_WID);
`endif
    base_addr = b; length = l; start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    budget = 30 + 8 * int'(l);
    n = 0;
    while (done_n == 0 && err_n == 0 && n < budget) begin
      if (spur && n == 3) begin
        start = 1'b1; base_addr = 18'h00500; length = 19'd3;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    repeat (5) tick();
    if (bad) begin
      chk({tag, "_err_pulses"}, 64'(err_n), 64'd1);
      chk({tag, "_err_cycle"}, 64'(err_cyc), 64'(c0));
      chk({tag, "_beats"}, 64'(got_d.size()), 64'd0);
      chk({tag, "_done"}, 64'(done_n), 64'd0);
      chk({tag, "_busy"}, 64'(busy_seen), 64'd0);
    end else begin
      chk({tag, "_err_pulses"}, 64'(err_n), 64'd0);
      chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
      chk({tag, "_beats"}, 64'(got_d.size()), 64'(l));
      for (int i = 0; i < got_d.size() && i < int'(l); i++) begin
        a = b + PTR_WID'(i);
        chk({tag, "_data"}, 64'(got_d[i]), 64'(mem_fn(a)));
        chk({tag, "_last"}, 64'(got_l[i]), 64'(i == int'(l) - 1));
        if (lat) chk({tag, "_beat_cycle"}, 64'(got_c[i]), 64'(c0 + 2 + i));
      end
      if (l == 0) begin
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(c0));
        chk({tag, "_busy_seen"}, 64'(busy_seen), 64'd0);
        chk({tag, "_valid_seen"}, 64'(valid_seen), 64'd0);
      end else if (got_c.size() > 0) begin
        chk({tag, "_done_with_last"}, 64'(done_cyc), 64'(got_c[got_c.size() - 1]));
      end
    end
    occ_on = 1'b0;
  endtask

  typedef struct {
    logic [PTR_WID-1:0] base;
    logic [PTR_WID:0]   len;
    int                 rm;
    bit                 lat;
    bit                 spur;
    int                 exp_n;
    logic [WIDTH-1:0]   exp_first;
    logic [WIDTH-1:0]   exp_final;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [PTR_WID-1:0] rb;
    logic [PTR_WID:0]   rl;

    vt[0] = '{18'h00010, 19'd4, 0, 1'b1, 1'b0, 4, 16'h0010, 16'h0013};
    vt[1] = '{18'h00020, 19'd8, 1, 1'b0, 1'b1, 8, 16'h0020, 16'h0027};
`ifdef DTW_REF_READER_RANGE_CHECK_EN
    vt[2] = '{18'h3FFFE, 19'd4, 0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
`else
    vt[2] = '{18'h3FFFE, 19'd4, 0, 1'b1, 1'b0, 4, 16'h3FFE, 16'h0001};
`endif
    vt[3] = '{18'h00100, 19'd0, 0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
    vt[4] = '{18'h002A5, 19'd1, 0, 1'b1, 1'b0, 1, 16'h02A5, 16'h02A5};
    vt[5] = '{18'h1FFF0, 19'd5, 2, 1'b0, 1'b0, 5, 16'hBFF0, 16'hBFF4};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    m_ready = 1'b0; occ_on = 1'b0; base_q = '0;
    clr_mon();
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_last_data", 64'({m_last, m_data}), 64'd0);
    rstn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_xfer($sformatf("vec%0d", v), vt[v].base, vt[v].len, vt[v].rm, vt[v].lat, vt[v].spur);
      chk($sformatf("vec%0d_count", v), 64'(got_d.size()), 64'(vt[v].exp_n));
      if (vt[v].exp_n > 0 && got_d.size() > 0) begin
        chk($sformatf("vec%0d_first", v), 64'(got_d[0]), 64'(vt[v].exp_first));
        chk($sformatf("vec%0d_final", v), 64'(got_d[got_d.size() - 1]), 64'(vt[v].exp_final));
      end
    end

    // Abort with five beats taken and the consumer stalled
    clr_mon();
    base_q = 18'h00040; occ_on = 1'b1; rdy_lim = 5; rdy_mode = 3; set_ready();
    base_addr = 18'h00040; length = 19'd16; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 60 && got_d.size() < 5; n++) tick();
    repeat (3) tick();
    chk("abort_beats_before", 64'(got_d.size()), 64'd5);
    for (int i = 0; i < got_d.size(); i++)
      chk("abort_beat_data", 64'(got_d[i]), 64'(mem_fn(18'h00040 + PTR_WID'(i))));
    chk("abort_stalled_valid", 64'(m_valid), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rdy_mode = 0; set_ready();
    chk("abort_valid_low", 64'(m_valid), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_no_done_now", 64'(done), 64'd0);
    repeat (6) tick();
    chk("abort_no_done", 64'(done_n), 64'd0);
    chk("abort_no_more_beats", 64'(got_d.size()), 64'd5);
    occ_on = 1'b0;
    run_xfer("after_abort", 18'h00060, 19'd2, 0, 1'b1, 1'b0);

    // Reset in the middle of a length-10 transfer
    clr_mon();
    rdy_mode = 0; set_ready();
    base_addr = 18'h00080; length = 19'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rstn = 1'b0; start = 1'b1; base_addr = 18'h00900; length = 19'd3;
    tick();
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_valid", 64'(m_valid), 64'd0);
    chk("midrst_last_data", 64'({m_last, m_data}), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    nb = got_d.size();
    repeat (2) tick();
    start = 1'b0;
    rstn = 1'b1;
    repeat (8) tick();
    chk("midrst_no_beats_after", 64'(got_d.size()), 64'(nb));
    chk("midrst_no_done", 64'(done_n), 64'd0);
    chk("midrst_stays_idle", 64'(busy), 64'd0);
    run_xfer("after_reset", 18'h00A00, 19'd3, 0, 1'b1, 1'b0);

    // Random transfers, some close to the top of the address space
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) rb = PTR_WID'((1 << PTR_WID) - int'($urandom_range(1, 12)));
      else            rb = PTR_WID'($urandom_range(0, (1 << PTR_WID) - 1));
      rl = (PTR_WID + 1)'($urandom_range(1, 20));
      run_xfer($sformatf("rand%0d", k), rb, rl, 2, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
